// File: rtl/class_mem_scheduler.sv
// class_mem_scheduler: sequences class-memory loading from the host, then row sweeps per query
// with read-latency-aligned row tags.
module class_mem_scheduler #(
    parameter int FTWIDTH      = 8,
    parameter int ADDR_WIDTH   = 13,
    parameter int LOAD_WORDS   = 104000,
    parameter int NUM_ROWS     = 6500,
    parameter int RD_LAT       = 1,
    parameter int DONE_TIMEOUT = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start_load,
    input  logic [FTWIDTH-1:0]    in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  query_start,
    output logic [FTWIDTH-1:0]    mem_class_in,
    output logic                  mem_we,
    output logic                  mem_re,
    output logic [ADDR_WIDTH-1:0] mem_read_address,
    input  logic                  mem_write_done,
    output logic                  row_valid,
    output logic [ADDR_WIDTH-1:0] row_idx,
    output logic                  sweep_done,
    output logic                  loaded,
    output logic                  busy,
    output logic                  err
);
    localparam int CW = $clog2(LOAD_WORDS + 1);
    localparam int TW = $clog2(DONE_TIMEOUT + RD_LAT + 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_ROW = ADDR_WIDTH'(NUM_ROWS - 1);

    typedef enum logic [2:0] {IDLE, LOAD, WAIT_DONE, READY, SWEEP, DRAIN, ERROR} state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [TW-1:0]         tmr_q, tmr_d;
    logic [ADDR_WIDTH-1:0] row_q, row_d;
    logic                  loaded_q, loaded_d, done_q;
    logic [RD_LAT-1:0]     pv_q;
    logic [ADDR_WIDTH-1:0] pa_q [RD_LAT];
    logic                  accept;

    assign in_ready         = state_q == LOAD;
    assign accept           = in_valid & in_ready;
    assign mem_we           = accept;
    assign mem_class_in     = in_ready ? in_data : '0;
    assign mem_re           = state_q == SWEEP || state_q == DRAIN;
    assign mem_read_address = row_q;
    assign row_valid        = pv_q[RD_LAT-1];
    assign row_idx          = pa_q[RD_LAT-1];
    assign sweep_done       = done_q;
    assign loaded           = loaded_q;
    assign busy             = !(state_q == IDLE || state_q == READY);
    assign err              = state_q == ERROR;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        tmr_d    = tmr_q;
        row_d    = row_q;
        loaded_d = loaded_q;
        case (state_q)
            IDLE:  if (start_load) state_d = LOAD;
            LOAD: begin
                if (accept) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CW'(LOAD_WORDS - 1)) begin
                        state_d = WAIT_DONE;
                        tmr_d   = '0;
                    end
                end
            end
            WAIT_DONE: begin
                tmr_d = tmr_q + 1'b1;
                if (mem_write_done) begin
                    state_d  = READY;
                    loaded_d = 1'b1;
                end else if (tmr_q == TW'(DONE_TIMEOUT - 1)) begin
                    state_d = ERROR;
                end
            end
            READY: begin
                if (query_start) begin
                    state_d = SWEEP;
                    row_d   = '0;
                end
            end
            SWEEP: begin
                if (row_q == LAST_ROW) begin
                    state_d = DRAIN;
                    tmr_d   = '0;
                end else begin
                    row_d = row_q + 1'b1;
                end
            end
            DRAIN: begin
                tmr_d = tmr_q + 1'b1;
                if (tmr_q == TW'(RD_LAT - 1)) state_d = READY;
            end
            default: ;
        endcase
    end

    // Issue tag pipeline mirrors the memory read latency so row_valid lines up with class_out.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            tmr_q    <= '0;
            row_q    <= '0;
            loaded_q <= 1'b0;
            done_q   <= 1'b0;
            pv_q     <= '0;
            for (int i = 0; i < RD_LAT; i++) pa_q[i] <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            tmr_q    <= tmr_d;
            row_q    <= row_d;
            loaded_q <= loaded_d;
            done_q   <= row_valid && row_idx == LAST_ROW;
            pv_q[0]  <= state_q == SWEEP;
            pa_q[0]  <= row_q;
            for (int i = 1; i < RD_LAT; i++) begin
                pv_q[i] <= pv_q[i-1];
                pa_q[i] <= pa_q[i-1];
            end
        end
    end
endmodule

// File: tb/tb_class_mem_scheduler.sv
// tb_class_mem_scheduler: randomized scoreboard bench; drivers queue cycle-tagged expectations,
// a negedge monitor compares every memory-side output against them.
module tb_class_mem_scheduler;
    localparam int FW = 8, AW = 6, LW = 37, NR = 23, RL = 2, TO = 12;

    logic          clk = 1'b0, reset = 1'b1, start_load = 1'b0, in_valid = 1'b0, query_start = 1'b0;
    logic          mem_write_done = 1'b0;
    logic [FW-1:0] in_data = '0;
    logic          in_ready, mem_we, mem_re, row_valid, sweep_done, loaded, busy, err;
    logic [FW-1:0] mem_class_in;
    logic [AW-1:0] mem_read_address, row_idx;

    class_mem_scheduler #(.FTWIDTH(FW), .ADDR_WIDTH(AW), .LOAD_WORDS(LW), .NUM_ROWS(NR),
                          .RD_LAT(RL), .DONE_TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .start_load(start_load), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .query_start(query_start), .mem_class_in(mem_class_in), .mem_we(mem_we),
        .mem_re(mem_re), .mem_read_address(mem_read_address), .mem_write_done(mem_write_done),
        .row_valid(row_valid), .row_idx(row_idx), .sweep_done(sweep_done), .loaded(loaded),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {int cyc; int val;} ev_t;
    ev_t we_q[$], addr_q[$], row_q[$];
    int  done_q[$];
    int  cyc = 0, total = 0, passes = 0, we_seen = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    always @(negedge clk) begin
        bit e;
        e = we_q.size() > 0 && we_q[0].cyc == cyc;
        if (e || mem_we) chk("mem_we", mem_we, e);
        if (e && mem_we) chk("mem_class_in", mem_class_in, we_q[0].val);
        if (e) void'(we_q.pop_front());
        if (mem_we) we_seen++;
        e = addr_q.size() > 0 && addr_q[0].cyc == cyc;
        if (e) begin
            chk("mem_re", mem_re, 1);
            chk("mem_read_address", mem_read_address, addr_q[0].val);
            void'(addr_q.pop_front());
        end
        e = row_q.size() > 0 && row_q[0].cyc == cyc;
        if (e || row_valid) chk("row_valid", row_valid, e);
        if (e && row_valid) chk("row_idx", row_idx, row_q[0].val);
        if (e) void'(row_q.pop_front());
        e = done_q.size() > 0 && done_q[0] == cyc;
        if (e || sweep_done) chk("sweep_done", sweep_done, e);
        if (e) void'(done_q.pop_front());
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        start_load = 0; query_start = 0; in_valid = 0;
    endtask

    task automatic reset_dut();
        int c;
        c = cyc;
        reset = 1; mem_write_done = 0; quiet();
        while (we_q.size() > 0 && we_q[$].cyc > c) void'(we_q.pop_back());
        while (addr_q.size() > 0 && addr_q[$].cyc > c) void'(addr_q.pop_back());
        while (row_q.size() > 0 && row_q[$].cyc > c) void'(row_q.pop_back());
        while (done_q.size() > 0 && done_q[$] > c) void'(done_q.pop_back());
        step();
        reset = 0;
    endtask

    // mode 0: always valid, 1: alternating, 2: random bubbles. Bytes past LW are offered but must not land.
    task automatic do_load(input int mode, input int extra, input bit with_q, input bit give_done);
        int offered, acc, k, last_c, base;
        bit v, rdy;
        logic [FW-1:0] d;
        base = we_seen;
        step();
        start_load = 1; query_start = with_q; in_valid = 1; in_data = 8'hAA;
        step();
        quiet();
        offered = 0; acc = 0; k = 0; last_c = cyc;
        while (offered < LW + extra) begin
            v = mode == 0 ? 1'b1 : mode == 1 ? (k % 2 == 0) : ($urandom_range(0, 3) != 0);
            d = FW'($urandom_range(0, 255));
            rdy = acc < LW;
            in_valid = v; in_data = d;
            if (v && rdy) begin
                we_q.push_back('{cyc, int'(d)});
                acc++;
                last_c = cyc;
            end
            if (v) offered++;
            @(negedge clk);
            chk("in_ready", in_ready, rdy);
            step();
            k++;
        end
        in_valid = 0;
        if (!give_done) begin
            while (cyc < last_c + TO) step();
            @(negedge clk);
            chk("err_before_timeout", err, 0);
            step();
            @(negedge clk);
            chk("err_at_timeout", err, 1);
            chk("busy_in_error", busy, 1);
            return;
        end
        while (cyc < last_c + 3) step();
        @(negedge clk);
        chk("loaded_waiting", loaded, 0);
        chk("busy_waiting", busy, 1);
        chk("in_ready_waiting", in_ready, 0);
        mem_write_done = 1;
        step();
        @(negedge clk);
        chk("loaded", loaded, 1);
        chk("busy_ready", busy, 0);
        chk("bytes_written", we_seen - base, LW);
    endtask

    // abort < 0 runs a full sweep; otherwise reset is applied while row 'abort' is presented.
    task automatic do_sweep(input bit poke, input int abort);
        int c;
        step();
        quiet();
        query_start = 1;
        c = cyc;
        for (int r = 0; r < NR; r++) begin
            addr_q.push_back('{c + 1 + r, r});
            row_q.push_back('{c + 1 + r + RL, r});
        end
        done_q.push_back(c + NR + RL + 1);
        if (abort >= 0) begin
            while (cyc < c + 1 + abort) begin
                step();
                quiet();
            end
            reset_dut();
            @(negedge clk);
            chk("abort_row_valid", row_valid, 0);
            chk("abort_mem_re", mem_re, 0);
            chk("abort_loaded", loaded, 0);
            chk("abort_busy", busy, 0);
            repeat (NR + RL + 2) step();
            return;
        end
        while (cyc < c + NR + RL) begin
            step();
            query_start = poke && $urandom_range(0, 2) == 0;
            start_load = poke && $urandom_range(0, 2) == 0;
            in_valid = start_load;
            in_data = FW'($urandom_range(0, 255));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        repeat (3) step();
        @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_re", mem_re, 0);
        chk("rst_addr", mem_read_address, 0);
        chk("rst_row_valid", row_valid, 0);
        chk("rst_row_idx", row_idx, 0);
        chk("rst_sweep_done", sweep_done, 0);
        chk("rst_loaded", loaded, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        reset = 0;

        do_load(0, 2, 0, 1);
        do_sweep(1, -1);
        do_sweep(0, -1);
        step();
        quiet();
        start_load = 1; in_valid = 1; in_data = 8'h5A;
        @(negedge clk);
        chk("ready_in_ready", in_ready, 0);
        step();
        quiet();
        @(negedge clk);
        chk("ready_busy", busy, 0);
        chk("ready_loaded", loaded, 1);
        do_sweep(1, -1);

        reset_dut();
        do_load(1, 3, 1, 1);
        do_sweep(0, NR / 2);

        do_load(2, 0, 0, 0);
        step();
        query_start = 1;
        step();
        quiet();
        repeat (3) step();
        @(negedge clk);
        chk("error_sticky", err, 1);
        chk("error_mem_re", mem_re, 0);
        chk("error_loaded", loaded, 0);
        reset_dut();
        @(negedge clk);
        chk("err_cleared", err, 0);
        chk("busy_cleared", busy, 0);

        repeat (4) step();
        chk("scoreboard_drained", we_q.size() + addr_q.size() + row_q.size() + done_q.size(), 0);
        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule
